// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN           datapath width
//   NOP_INSTR_DEF  bubble word (ADDI x0,x0,0)
//   RESET_PC_DEF   PC loaded on reset
//   if_id_t        IF/ID pipeline record {pc, instr, valid}
//   word_align     clears the two byte-offset bits of an address
package instruction_fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus bundle: decode/execute control, instruction memory port and
// the IF/ID outputs.
//   slave  : the fetch stage (drives pcAddress and the id* outputs)
//   master : surrounding pipeline / memory (drives stall, branch, instruction)
interface instruction_fetch_stage_if;
  import instruction_fetch_stage_pkg::*;
  logic            stall;
  logic            branchTaken;
  logic [XLEN-1:0] branchTarget;
  logic [XLEN-1:0] pcAddress;
  logic [XLEN-1:0] instruction;
  logic [XLEN-1:0] idPc;
  logic [XLEN-1:0] idInstruction;
  logic            idValid;
  logic [XLEN-1:0] fetchCount;

  modport slave (
    input  stall, branchTaken, branchTarget, instruction,
    output pcAddress, idPc, idInstruction, idValid, fetchCount
  );
  modport master (
    output stall, branchTaken, branchTarget, instruction,
    input  pcAddress, idPc, idInstruction, idValid, fetchCount
  );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
//   clk, rst_n : clock, async active-low reset (resets to a bubble)
//   load       : capture d
//   flush      : replace contents with a bubble tagged with d.pc (wins over hold)
//   hold       : keep current contents
//   d / q      : IF/ID record in / out
module if_id_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   flush,
  input  logic   hold,
  input  if_id_t d,
  output if_id_t q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (flush) begin
      q <= '{pc: d.pc, instr: NOP_INSTR, valid: 1'b0};
    end else if (!hold && load) begin
      q <= d;
    end
  end
endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, zero-latency instruction memory
// interface and IF/ID register. Per edge: branch redirect > stall > advance.
//   clk, rst_n : clock, async active-low reset
//   bus        : instruction_fetch_stage_if.slave (stall, branchTaken,
//                branchTarget, instruction in; pcAddress, idPc, idInstruction,
//                idValid, fetchCount out)
// Optional feature macro: IF_FETCH_COUNT_EN -- when defined, fetchCount counts
// normal-advance edges; otherwise it is tied to zero.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_stage_if.slave  bus
);
  logic [XLEN-1:0] pc;
  logic            advance;
  if_id_t          if_d, if_q;

  assign advance = !bus.branchTaken && !bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pc <= word_align(RESET_PC);
    else if (bus.branchTaken) pc <= word_align(bus.branchTarget);
    else if (!bus.stall)      pc <= pc + XLEN'(4); // wraps modulo 2^32
  end

  // memory is word indexed
  assign bus.pcAddress = {2'b00, pc[XLEN-1:2]};

  assign if_d = '{pc: pc, instr: bus.instruction, valid: 1'b1};

  if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (advance),
    .flush (bus.branchTaken),
    .hold  (bus.stall),
    .d     (if_d),
    .q     (if_q)
  );

  assign bus.idPc          = if_q.pc;
  assign bus.idInstruction = if_q.instr;
  assign bus.idValid       = if_q.valid;

`ifdef IF_FETCH_COUNT_EN
  logic [XLEN-1:0] fetch_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fetch_cnt <= '0;
    else if (advance) fetch_cnt <= fetch_cnt + XLEN'(1);
  end
  assign bus.fetchCount = fetch_cnt;
`else
  assign bus.fetchCount = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  instruction_fetch_stage_if bus();

  instruction_fetch_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // instruction memory: three directed words then a recognisable pattern
  always_comb begin
    case (bus.pcAddress)
      32'd0:   bus.instruction = 32'h0000_0013;
      32'd1:   bus.instruction = 32'h0000_0093;
      32'd2:   bus.instruction = 32'h0010_0113;
      default: bus.instruction = 32'hA000_0000 | bus.pcAddress;
    endcase
  end

  typedef struct {
    logic [31:0] pa, ipc, ins;
    logic        v;
    logic [31:0] n;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] ec(input int n);
`ifdef IF_FETCH_COUNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".pcAddress"},     bus.pcAddress,        e.pa);
    chk({tag, ".idPc"},          bus.idPc,             e.ipc);
    chk({tag, ".idInstruction"}, bus.idInstruction,    e.ins);
    chk({tag, ".idValid"},       {31'd0, bus.idValid}, {31'd0, e.v});
    chk({tag, ".fetchCount"},    bus.fetchCount,       e.n);
  endtask

  // monitor: compare each edge's expectation away from the active edge
  int edge_no = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        edge_no++;
        chk_all($sformatf("edge%0d", edge_no), e);
      end
    end
  end

  task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                      input logic [31:0] pa, input logic [31:0] ipc,
                      input logic [31:0] ins, input logic v, input int n);
    bus.stall = st;
    bus.branchTaken = br;
    bus.branchTarget = tgt;
    @(posedge clk);
    sbq.push_back('{pa: pa, ipc: ipc, ins: ins, v: v, n: ec(n)});
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t rst_e;
    rst_e = '{pa: 32'd0, ipc: 32'd0, ins: 32'h13, v: 1'b0, n: 32'd0};
    bus.stall = 1'b0;
    bus.branchTaken = 1'b0;
    bus.branchTarget = 32'd0;
    repeat (2) @(negedge clk);
    chk_all("reset", rst_e);
    rst_n = 1'b1;

    //    st br target        pcAddr        idPc          idInstr       v  cnt
    step(0, 0, 32'h0,        32'd1,        32'h0,        32'h13,       1, 1);
    step(0, 0, 32'h0,        32'd2,        32'h4,        32'h93,       1, 2);
    // stall three cycles at pc=8
    step(1, 0, 32'h0,        32'd2,        32'h4,        32'h93,       1, 2);
    step(1, 0, 32'h0,        32'd2,        32'h4,        32'h93,       1, 2);
    step(1, 0, 32'h0,        32'd2,        32'h4,        32'h93,       1, 2);
    step(0, 0, 32'h0,        32'd3,        32'h8,        32'h00100113, 1, 3);
    // branch with stall: branch wins
    step(1, 1, 32'h40,       32'h10,       32'hC,        32'h13,       0, 3);
    step(0, 0, 32'h0,        32'h11,       32'h40,       32'hA0000010, 1, 4);
    // misaligned target is silently aligned
    step(0, 1, 32'h43,       32'h10,       32'h44,       32'h13,       0, 4);
    // park pc at the top of the address space, then wrap
    step(0, 1, 32'hFFFFFFFF, 32'h3FFFFFFF, 32'h40,       32'h13,       0, 4);
    step(0, 0, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hBFFFFFFF, 1, 5);
    step(0, 0, 32'h0,        32'h1,        32'h0,        32'h13,       1, 6);
    step(0, 0, 32'h0,        32'h2,        32'h4,        32'h93,       1, 7);

    // asynchronous reset mid-cycle with a branch and stall pending
    #2;
    bus.branchTaken = 1'b1;
    bus.stall = 1'b1;
    bus.branchTarget = 32'h80;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", rst_e);
    @(posedge clk);
    #1;
    chk_all("rst_held", rst_e);
    @(negedge clk);
    bus.branchTaken = 1'b0;
    bus.stall = 1'b0;
    rst_n = 1'b1;
    step(0, 0, 32'h0,        32'd1,        32'h0,        32'h13,       1, 1);

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      failures++;
      checks++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
